// File: rtl/dispatch2.sv
// dispatch2: clocked 4-phase demux steering one bundled-data request
// channel onto one of two output channels, chosen by sel_i per transfer.
module dispatch2 #(
  parameter int unsigned N    = 32'd1,
  parameter int unsigned SYNC = 32'd2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         sel_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    ACK,
    RTZ
  } state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [SYNC-1:0] r_rsync;
  logic [SYNC-1:0] r_a0sync;
  logic [SYNC-1:0] r_a1sync;
  logic           r_sel;
  logic           w_rs;
  logic           w_as;
  logic           w_ld;
  logic           w_req;
  logic           w_ack;

  assign w_rs = r_rsync[SYNC-1];
  assign w_as = r_sel ? r_a1sync[SYNC-1]
                      : r_a0sync[SYNC-1];
  assign w_ld = (r_state == IDLE) && w_rs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsync  <= '0;
      r_a0sync <= '0;
      r_a1sync <= '0;
    end else begin
      r_rsync  <= {r_rsync[SYNC-2:0], r_i};
      r_a0sync <= {r_a0sync[SYNC-2:0], a_o};
      r_a1sync <= {r_a1sync[SYNC-2:0], a1_o};
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_rs) w_nxt = LOAD;
      LOAD:    w_nxt = REQ;
      REQ:     if (w_as) w_nxt = ACK;
      ACK:     if (!w_rs) w_nxt = RTZ;
      RTZ:     if (!w_as) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each lands in its own flop.
  assign w_req = (w_nxt == REQ) || (w_nxt == ACK);
  assign w_ack = (w_nxt == ACK) || (w_nxt == RTZ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      a_i     <= 1'b0;
      r_o     <= 1'b0;
      r1_o    <= 1'b0;
      d_o     <= '0;
      d1_o    <= '0;
    end else begin
      r_state <= w_nxt;
      a_i     <= w_ack;
      r_o     <= w_req && !r_sel;
      r1_o    <= w_req && r_sel;
      // Output data regs double as the capture regs: valid through LOAD.
      if (w_ld) begin
        r_sel <= sel_i;
        if (sel_i) d1_o <= d_i;
        else       d_o  <= d_i;
      end
    end
  end

endmodule
